param_queue: RTL and testbench
==============================

// Module: param_queue
// PURPOSE
// - Parametrised circular FIFO for deserializer output: words enter on enq_in, leave on deq_in.
// - Successor to the fixed 8x8 queue. Adds configurable width/depth and a correct same-cycle enqueue+dequeue.
// - Adds full/empty/almost-full flags, coded error status, a synchronous flush and a data_out valid strobe.
// PARAMETERS
// - WIDTH     8   data word width in bits
// - DEPTH     8   number of entries; >=2, need not be a power of two
// - AF_LEVEL  6   almost_full_out threshold; 1..DEPTH
// - CNT_W     8   width of drop counter (macro build only)
// PORTS
// - clock_10k        in   1                     single system clock, rising edge
// - reset            in   1                     synchronous, active-high
// - data_in          in   WIDTH                 word to enqueue
// - enq_in           in   1                     enqueue request, sampled each edge
// - deq_in           in   1                     dequeue request, sampled each edge
// - clear_in         in   1                     synchronous flush
// - data_out         out  WIDTH                 last dequeued word, registered
// - data_valid_out   out  1                     1-cycle pulse: data_out updated this cycle
// - ack_in_q         out  1                     1-cycle pulse: data_in was accepted
// - len_out          out  $clog2(DEPTH+1)       current occupancy, 0..DEPTH
// - full_out         out  1                     len_out == DEPTH
// - empty_out        out  1                     len_out == 0
// - almost_full_out  out  1                     len_out >= AF_LEVEL
// - status_out       out  2                     queue_pkg::q_status_e, 1-cycle pulse
// - drop_cnt_out     out  CNT_W                 exists only with PARAM_QUEUE_DROP_CNT_EN
// BEHAVIOUR
// - Reset (sync, highest priority): all outputs 0 except empty_out=1, status_out=Q_OK; head=tail=0.
//   - Storage array is not cleared.
// - All outputs are registered. Effects of requests sampled at edge N are visible after edge N.
// - Enqueue is accepted when enq_in=1 and either len<DEPTH, or len==DEPTH with a dequeue accepted that same cycle.
//   - On acceptance: mem[tail]<=data_in, tail advances, ack_in_q=1.
// - Dequeue is accepted when deq_in=1 and len>0, evaluated on the pre-edge len. There is no empty bypass.
//   - On acceptance: data_out<=mem[head], data_valid_out=1, head advances.
// - Same-cycle enqueue and dequeue, both accepted: len unchanged. On a full queue, the read uses the old head.
// - len update: +1 if only enqueue accepted, -1 if only dequeue accepted, else unchanged. Never outside 0..DEPTH.
// - Pointer wrap: ptr==DEPTH-1 -> 0 by explicit compare, not modulo.
// - status_out: Q_OVERFLOW if enqueue rejected, Q_UNDERFLOW if dequeue rejected, else Q_OK.
//   - Both cannot occur in one cycle when DEPTH>=2.
// - clear_in: head=tail=len=0 and flags update. Same-cycle enq_in/deq_in are ignored, with no ack, valid or error.
//   - data_out holds its value.
// - Reset or clear mid-stream discards contents. The first accepted enqueue afterwards lands in mem[0].
// - Pulse outputs (ack_in_q, data_valid_out, status_out) return to 0/Q_OK on the next edge unless re-triggered.
// CONFIGURATION
// - PARAM_QUEUE_DROP_CNT_EN defined:
//   - drop_cnt_out counts rejected enqueues (overflows) and saturates at 2^CNT_W-1.
//   - It is cleared by reset and clear_in.
// - PARAM_QUEUE_DROP_CNT_EN undefined: the port and the counter are absent. All other behaviour is identical.
// STRUCTURE
// - queue_pkg: typedef enum logic[1:0] q_status_e {Q_OK=0, Q_OVERFLOW=1, Q_UNDERFLOW=2}.
//   - Also holds the function ptr_next(ptr, DEPTH).
// - Sub-module queue_ram #(WIDTH,DEPTH): sync write port; read port registered into data_out.
// - Parent holds pointers, len, flags, status and the optional counter.
// TESTING (WIDTH=8, DEPTH=4, AF_LEVEL=3)
// - Reset, then idle:
//   - len_out=0, empty_out=1, full_out=0, status_out=Q_OK, ack_in_q=0, data_valid_out=0.
// - Enqueue A1,B2,C3,D4, then dequeue 4x:
//   - ack_in_q on each enqueue; almost_full_out at len 3, full_out at len 4.
//   - data_out A1,B2,C3,D4 each with data_valid_out; ends empty.
// - Full queue, enq E5 alone:
//   - status_out=Q_OVERFLOW for 1 cycle, len stays 4, no ack_in_q; drop_cnt_out=1 if macro set.
// - Full queue [A1..D4], enq F6 + deq together:
//   - data_out=A1, ack_in_q=1, len stays 4; 4 further dequeues give B2,C3,D4,F6 (tail wrap).
// - Empty queue, deq alone -> status_out=Q_UNDERFLOW. Empty queue, enq 77 + deq together -> 77 stored, len=1, underflow flagged.
// - len=3, clear_in with enq_in=1 -> len=0, no ack; next enq 99, then deq -> data_out=99 (read from mem[0]).

Source files
------------

// File: rtl/queue_pkg.sv
// Shared types and helpers for the parametrised queue: status encoding and pointer advance.
package queue_pkg;

  typedef enum logic [1:0] {
    Q_OK        = 2'd0,
    Q_OVERFLOW  = 2'd1,
    Q_UNDERFLOW = 2'd2
  } q_status_e;

  // Wrap by explicit compare so DEPTH need not be a power of two.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/queue_ram.sv
// Queue storage: synchronous write port, registered read port that drives the queue's data_out.
module queue_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/param_queue.sv
// Parametrised circular FIFO with flags, status pulses and flush.
// Optional overflow drop counter enabled by defining PARAM_QUEUE_DROP_CNT_EN.
module param_queue
  import queue_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
`ifdef PARAM_QUEUE_DROP_CNT_EN
  , parameter int CNT_W  = 8
`endif
) (
  input  logic                       clock_10k,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       enq_in,
  input  logic                       deq_in,
  input  logic                       clear_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  output logic                       ack_in_q,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       full_out,
  output logic                       empty_out,
  output logic                       almost_full_out,
  output q_status_e                  status_out
`ifdef PARAM_QUEUE_DROP_CNT_EN
  , output logic [CNT_W-1:0]         drop_cnt_out
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_head, r_tail;
  logic [LEN_W-1:0] r_len;
  logic             r_full, r_empty, r_af, r_ack, r_valid;
  q_status_e        r_status;

  logic             w_enq_ok, w_deq_ok;
  logic [LEN_W-1:0] w_len_nxt;
  logic [PTR_W-1:0] w_head_nxt, w_tail_nxt;
  q_status_e        w_status;

  // Dequeue uses pre-edge len (no empty bypass); a full queue may still accept
  // an enqueue when a dequeue frees the slot in the same cycle.
  assign w_deq_ok = deq_in && !clear_in && !reset && (r_len != '0);
  assign w_enq_ok = enq_in && !clear_in && !reset &&
                    ((r_len != LEN_W'(DEPTH)) || w_deq_ok);

  assign w_head_nxt = PTR_W'(ptr_next(32'(r_head), DEPTH));
  assign w_tail_nxt = PTR_W'(ptr_next(32'(r_tail), DEPTH));

  always_comb begin
    w_len_nxt = r_len;
    if (clear_in)                  w_len_nxt = '0;
    else if (w_enq_ok && !w_deq_ok) w_len_nxt = r_len + LEN_W'(1);
    else if (w_deq_ok && !w_enq_ok) w_len_nxt = r_len - LEN_W'(1);
  end

  always_comb begin
    w_status = Q_OK;
    if (!clear_in) begin
      if (enq_in && !w_enq_ok)      w_status = Q_OVERFLOW;
      else if (deq_in && !w_deq_ok) w_status = Q_UNDERFLOW;
    end
  end

  always_ff @(posedge clock_10k) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_len    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ack    <= 1'b0;
      r_valid  <= 1'b0;
      r_status <= Q_OK;
    end else begin
      if (clear_in) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_deq_ok) r_head <= w_head_nxt;
        if (w_enq_ok) r_tail <= w_tail_nxt;
      end
      r_len    <= w_len_nxt;
      r_full   <= (w_len_nxt == LEN_W'(DEPTH));
      r_empty  <= (w_len_nxt == '0);
      r_af     <= (w_len_nxt >= LEN_W'(AF_LEVEL));
      r_ack    <= w_enq_ok;
      r_valid  <= w_deq_ok;
      r_status <= w_status;
    end
  end

  queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .i_clk   (clock_10k),
    .i_rst   (reset),
    .i_we    (w_enq_ok),
    .i_waddr (r_tail),
    .i_wdata (data_in),
    .i_re    (w_deq_ok),
    .i_raddr (r_head),
    .o_rdata (data_out)
  );

`ifdef PARAM_QUEUE_DROP_CNT_EN
  logic [CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clock_10k) begin
    if (reset || clear_in)
      r_drop_cnt <= '0;
    else if (enq_in && !w_enq_ok && (r_drop_cnt != {CNT_W{1'b1}}))
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
  end

  assign drop_cnt_out = r_drop_cnt;
`endif

  assign data_valid_out  = r_valid;
  assign ack_in_q        = r_ack;
  assign len_out         = r_len;
  assign full_out        = r_full;
  assign empty_out       = r_empty;
  assign almost_full_out = r_af;
  assign status_out      = r_status;

endmodule

// File: tb/tb_param_queue.sv
// Directed plus random bench for param_queue (WIDTH=8, DEPTH=4, AF_LEVEL=3) using a queue reference model.
module tb_param_queue;
  import queue_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;

  logic         clk = 1'b0;
  logic         reset, enq_in, deq_in, clear_in;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         data_valid_out, ack_in_q, full_out, empty_out, almost_full_out;
  logic [2:0]   len_out;
  q_status_e    status_out;
`ifdef PARAM_QUEUE_DROP_CNT_EN
  logic [7:0]   drop_cnt_out;
  int           exp_drop = 0;
`endif

  int           n_chk = 0;
  int           n_err = 0;
  logic [W-1:0] model[$];
  logic [W-1:0] sb[$];
  logic [W-1:0] last_data = '0;

  always #5 clk = ~clk;

  param_queue #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
    .clock_10k       (clk),
    .reset           (reset),
    .data_in         (data_in),
    .enq_in          (enq_in),
    .deq_in          (deq_in),
    .clear_in        (clear_in),
    .data_out        (data_out),
    .data_valid_out  (data_valid_out),
    .ack_in_q        (ack_in_q),
    .len_out         (len_out),
    .full_out        (full_out),
    .empty_out       (empty_out),
    .almost_full_out (almost_full_out),
    .status_out      (status_out)
`ifdef PARAM_QUEUE_DROP_CNT_EN
    , .drop_cnt_out  (drop_cnt_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    int sz;
    sz = model.size();
    chk({tag, ":len"},   32'(len_out),         32'(sz));
    chk({tag, ":full"},  32'(full_out),        32'(sz == D));
    chk({tag, ":empty"}, 32'(empty_out),       32'(sz == 0));
    chk({tag, ":af"},    32'(almost_full_out), 32'(sz >= AF));
`ifdef PARAM_QUEUE_DROP_CNT_EN
    chk({tag, ":drop"},  32'(drop_cnt_out),    32'(exp_drop));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enq_in = 1'b0; deq_in = 1'b0; clear_in = 1'b0; data_in = '0;
    @(posedge clk);
    @(negedge clk);
    model.delete(); sb.delete(); last_data = '0;
`ifdef PARAM_QUEUE_DROP_CNT_EN
    exp_drop = 0;
`endif
    chk("rst:data",   32'(data_out),       0);
    chk("rst:valid",  32'(data_valid_out), 0);
    chk("rst:ack",    32'(ack_in_q),       0);
    chk("rst:status", 32'(status_out),     32'(Q_OK));
    chk_flags("rst");
    reset = 1'b0;
  endtask

  task automatic step(input string tag, input logic e, input logic d, input logic c, input logic [W-1:0] din);
    int  sz;
    bit  xd, xe;
    logic [1:0] xs;
    @(negedge clk);
    enq_in = e; deq_in = d; clear_in = c; data_in = din;
    sz = model.size();
    xd = d && !c && (sz > 0);
    xe = e && !c && ((sz < D) || xd);
    xs = c ? 2'd0 : (e && !xe) ? 2'd1 : (d && !xd) ? 2'd2 : 2'd0;
    if (xd) sb.push_back(model.pop_front());
    if (xe) model.push_back(din);
    if (c)  model.delete();
`ifdef PARAM_QUEUE_DROP_CNT_EN
    if (c) exp_drop = 0;
    else if (e && !xe && exp_drop < 255) exp_drop++;
`endif
    @(posedge clk);
    #1;
    chk({tag, ":ack"},    32'(ack_in_q),       32'(xe));
    chk({tag, ":valid"},  32'(data_valid_out), 32'(xd));
    chk({tag, ":status"}, 32'(status_out),     32'(xs));
    if (data_valid_out) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $error("FAIL %s:sb observed=valid expected=no_pending_word", tag);
      end else begin
        last_data = sb.pop_front();
        chk({tag, ":data"}, 32'(data_out), 32'(last_data));
      end
    end else begin
      chk({tag, ":hold"}, 32'(data_out), 32'(last_data));
    end
    chk_flags(tag);
  endtask

  initial begin
    reset = 1'b1; enq_in = 1'b0; deq_in = 1'b0; clear_in = 1'b0; data_in = '0;
    do_reset();
    step("idle", 0, 0, 0, 8'h00);

    step("enqA1", 1, 0, 0, 8'hA1);
    step("enqB2", 1, 0, 0, 8'hB2);
    step("enqC3", 1, 0, 0, 8'hC3);
    chk("af_at3", 32'(almost_full_out), 1);
    step("enqD4", 1, 0, 0, 8'hD4);
    chk("full_at4", 32'(full_out), 1);
    for (int i = 0; i < 4; i++) step("drain", 0, 1, 0, 8'h00);
    chk("drained_last", 32'(data_out), 32'hD4);

    step("fA1", 1, 0, 0, 8'hA1);
    step("fB2", 1, 0, 0, 8'hB2);
    step("fC3", 1, 0, 0, 8'hC3);
    step("fD4", 1, 0, 0, 8'hD4);
    step("ovfE5", 1, 0, 0, 8'hE5);
    chk("ovf_status", 32'(status_out), 32'(Q_OVERFLOW));
    step("ovf_clr", 0, 0, 0, 8'h00);
    chk("ovf_pulse", 32'(status_out), 32'(Q_OK));

    step("fullF6", 1, 1, 0, 8'hF6);
    chk("full_rw_data", 32'(data_out), 32'hA1);
    chk("full_rw_len", 32'(len_out), 4);
    for (int i = 0; i < 4; i++) step("wrap", 0, 1, 0, 8'h00);
    chk("wrap_last", 32'(data_out), 32'hF6);

    step("udf", 0, 1, 0, 8'h00);
    chk("udf_status", 32'(status_out), 32'(Q_UNDERFLOW));
    step("e77", 1, 1, 0, 8'h77);
    chk("e77_len", 32'(len_out), 1);
    step("d77", 0, 1, 0, 8'h00);
    chk("d77_data", 32'(data_out), 32'h77);

    step("c1", 1, 0, 0, 8'h11);
    step("c2", 1, 0, 0, 8'h22);
    step("c3", 1, 0, 0, 8'h33);
    step("clr", 1, 1, 1, 8'h44);
    chk("clr_len", 32'(len_out), 0);
    step("e99", 1, 0, 0, 8'h99);
    step("d99", 0, 1, 0, 8'h00);
    chk("d99_data", 32'(data_out), 32'h99);

    step("r1", 1, 0, 0, 8'h5A);
    step("r2", 1, 0, 0, 8'h6B);
    do_reset();
    step("post_rst_e", 1, 0, 0, 8'hC7);
    step("post_rst_d", 0, 1, 0, 8'h00);

    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 24) == 0), 8'($urandom_range(0, 255)));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
